// File: rtl/xor_load_seq.sv
// Serialises a 4-bit key and an 8-bit message into an XOR core, then waits for its done flag.
// Latency: key bits appear the cycle after accept; frame = 4*BIT_CYCLES key + BIT_CYCLES gap + 8*BIT_CYCLES msg + wait.
// Backpressure: oReady is high only in IDLE; iEn=0 freezes everything. Optional key cache: XOR_LOAD_SEQ_KEY_CACHE_EN.
module xor_load_seq #(
    parameter int BIT_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic [3:0] iKey,
    input  logic [7:0] iMsg,
    input  logic       iValid,
    input  logic       iXor_done,
    output logic       oReady,
    output logic       oData,
    output logic       oLoad_key,
    output logic       oLoad_msg,
    output logic       oFrame_done,
    output logic       oErr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_GAP,
        S_MSG,
        S_WAIT
    } state_t;

    // Last value of each counter; counters are sized for the parameter maxima (15 and 255).
    localparam logic [3:0] HOLD_LAST = 4'(BIT_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_key_sr;   // key bits still to send; bit 3 goes out directly at accept
    logic [7:0] r_msg_sr;
    logic [3:0] r_hold;
    logic [2:0] r_bit;
    logic [7:0] r_wait;

    logic w_accept;
    logic w_hold_end;
    logic w_cache_hit;

    assign w_accept   = (r_state == S_IDLE) & iValid & oReady & iEn;
    assign w_hold_end = (r_hold == HOLD_LAST);

`ifdef XOR_LOAD_SEQ_KEY_CACHE_EN
    logic [3:0] r_cache_key;
    logic       r_cache_vld;

    assign w_cache_hit = r_cache_vld & (iKey == r_cache_key);

    // Remember the key of the latest frame; a repeat of it skips the KEY and GAP phases.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_cache_key <= 4'd0;
            r_cache_vld <= 1'b0;
        end else if (w_accept) begin
            r_cache_key <= iKey;
            r_cache_vld <= 1'b1;
        end
    end
`else
    assign w_cache_hit = 1'b0;
`endif

    // Frame sequencer: all outputs registered, everything frozen while iEn is low.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state     <= S_IDLE;
            r_key_sr    <= 3'd0;
            r_msg_sr    <= 8'd0;
            r_hold      <= 4'd0;
            r_bit       <= 3'd0;
            r_wait      <= 8'd0;
            oReady      <= 1'b0;
            oData       <= 1'b0;
            oLoad_key   <= 1'b0;
            oLoad_msg   <= 1'b0;
            oFrame_done <= 1'b0;
            oErr        <= 1'b0;
        end else if (iEn) begin
            oFrame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    oReady <= 1'b1;
                    if (w_accept) begin
                        oReady   <= 1'b0;
                        oErr     <= 1'b0;
                        r_key_sr <= iKey[2:0];
                        r_msg_sr <= iMsg;
                        r_hold   <= 4'd0;
                        r_bit    <= 3'd0;
                        r_wait   <= 8'd0;
                        if (w_cache_hit) begin
                            r_state   <= S_MSG;
                            oLoad_msg <= 1'b1;
                            oData     <= iMsg[7];
                        end else begin
                            r_state   <= S_KEY;
                            oLoad_key <= 1'b1;
                            oData     <= iKey[3];
                        end
                    end
                end
                S_KEY: begin
                    if (w_hold_end) begin
                        r_hold <= 4'd0;
                        if (r_bit == 3'd3) begin
                            r_state   <= S_GAP;
                            r_bit     <= 3'd0;
                            oLoad_key <= 1'b0;
                            oData     <= 1'b0;
                        end else begin
                            r_bit    <= r_bit + 3'd1;
                            r_key_sr <= {r_key_sr[1:0], 1'b0};
                            oData    <= r_key_sr[2];
                        end
                    end else begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                S_GAP: begin
                    if (w_hold_end) begin
                        r_hold    <= 4'd0;
                        r_state   <= S_MSG;
                        oLoad_msg <= 1'b1;
                        oData     <= r_msg_sr[7];
                    end else begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                S_MSG: begin
                    if (w_hold_end) begin
                        r_hold <= 4'd0;
                        if (r_bit == 3'd7) begin
                            r_state   <= S_WAIT;
                            r_bit     <= 3'd0;
                            r_wait    <= 8'd0;
                            oLoad_msg <= 1'b0;
                            oData     <= 1'b0;
                        end else begin
                            r_bit    <= r_bit + 3'd1;
                            r_msg_sr <= {r_msg_sr[6:0], 1'b0};
                            oData    <= r_msg_sr[6];
                        end
                    end else begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (iXor_done) begin
                        r_state     <= S_IDLE;
                        oReady      <= 1'b1;
                        oFrame_done <= 1'b1;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state <= S_IDLE;
                        oReady  <= 1'b1;
                        oErr    <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_load_seq.sv
module tb_xor_load_seq;
    localparam int BC = 2;
    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] key;
    logic [7:0] msg;
    logic       valid;
    logic       xdone;
    logic       ready, data, load_key, load_msg, frame_done, err;

    always #5 clk = ~clk;

    xor_load_seq #(.BIT_CYCLES(BC), .TIMEOUT_CYCLES(TO)) dut (
        .iClk(clk), .iRst(rst_n), .iEn(en), .iKey(key), .iMsg(msg),
        .iValid(valid), .iXor_done(xdone), .oReady(ready), .oData(data),
        .oLoad_key(load_key), .oLoad_msg(load_msg), .oFrame_done(frame_done), .oErr(err)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] kb;
        int          kl;
        int          gl;
        logic [63:0] mb;
        int          ml;
        bit          err;
    } exp_t;

    exp_t       expq[$];
    bit         mc_vld = 1'b0;
    logic [3:0] mc_key = 4'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
        finish_run();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each bit repeated BC times MSB first, BC gap cycles unless the key phase is skipped.
    function automatic exp_t mk(input logic [3:0] k, input logic [7:0] m, input bit e_err, input bit cached);
        exp_t e;
        e.kb = 64'd0; e.kl = 0; e.mb = 64'd0; e.ml = 0;
        if (!cached)
            for (int i = 3; i >= 0; i--)
                for (int r = 0; r < BC; r++) begin e.kb = {e.kb[62:0], k[i]}; e.kl++; end
        e.gl = cached ? 0 : BC;
        for (int i = 7; i >= 0; i--)
            for (int r = 0; r < BC; r++) begin e.mb = {e.mb[62:0], m[i]}; e.ml++; end
        e.err = e_err;
        return e;
    endfunction

    // Monitor: collects one frame of serial output and compares it when the frame ends.
    logic [63:0] ok_bits, om_bits;
    int  okl, oml, ogl, kh, last_kh, overlap = 0;
    bit  gap_bad, seen_k, seen_m, p_done, p_err;

    task automatic clear_obs();
        ok_bits = 64'd0; om_bits = 64'd0; okl = 0; oml = 0; ogl = 0; kh = 0;
        gap_bad = 1'b0; seen_k = 1'b0; seen_m = 1'b0;
    endtask

    initial begin
        clear_obs();
        last_kh = 0; p_done = 1'b0; p_err = 1'b0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            clear_obs();
            p_done = 1'b0;
            p_err  = 1'b0;
        end else begin
            if (load_key && load_msg) overlap++;
            if (load_key) kh++;
            if (en) begin
                if (load_key) begin ok_bits = {ok_bits[62:0], data}; okl++; seen_k = 1'b1; end
                else if (load_msg) begin om_bits = {om_bits[62:0], data}; oml++; seen_m = 1'b1; end
                else if (seen_k && !seen_m) begin ogl++; if (data) gap_bad = 1'b1; end
            end
            if ((frame_done && !p_done) || (err && !p_err)) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: frame ended with nothing expected");
                end else begin
                    e = expq.pop_front();
                    chk("key_len", 64'(okl), 64'(e.kl));
                    chk("key_bits", ok_bits, e.kb);
                    chk("gap_len", 64'(ogl), 64'(e.gl));
                    chk("gap_data", 64'(gap_bad), 64'd0);
                    chk("msg_len", 64'(oml), 64'(e.ml));
                    chk("msg_bits", om_bits, e.mb);
                    chk("outcome_err", 64'(err && !p_err), 64'(e.err));
                end
                last_kh = kh;
                clear_obs();
            end
            p_done = frame_done;
            p_err  = err;
        end
    end

    // One frame: done_dly = WAIT_DONE cycle on which iXor_done rises, 0 means let it time out.
    task automatic run_frame(input logic [3:0] k, input logic [7:0] m, input int stall_at,
                             input int stall_len, input int done_dly, input bit pulse_valid,
                             input bit pulse_done_key);
        int  n;
        bit  cached;
        cached = 1'b0;
        n = 0;
        while (!ready) begin tick(); n++; if (n > 100) bound_fail("wait_ready"); end
`ifdef XOR_LOAD_SEQ_KEY_CACHE_EN
        cached = mc_vld && (k == mc_key);
`endif
        mc_vld = 1'b1;
        mc_key = k;
        expq.push_back(mk(k, m, done_dly == 0, cached));
        key = k; msg = m; valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("accept_strobes", {62'd0, load_key, load_msg}, cached ? 64'd1 : 64'd2);
        chk("accept_first_bit", 64'(data), cached ? 64'(m[7]) : 64'(k[3]));
        chk("accept_err_clear", 64'(err), 64'd0);
        chk("accept_ready_low", 64'(ready), 64'd0);
        if (pulse_done_key) begin xdone = 1'b1; tick(); xdone = 1'b0; end
        repeat (stall_at) tick();
        if (stall_len > 0) begin en = 1'b0; repeat (stall_len) tick(); en = 1'b1; end
        n = 0;
        while (!load_msg) begin tick(); n++; if (n > 100) bound_fail("wait_msg"); end
        if (pulse_valid) begin valid = 1'b1; tick(); valid = 1'b0; end
        n = 0;
        while (load_msg) begin tick(); n++; if (n > 100) bound_fail("wait_msg_end"); end
        if (done_dly > 0) begin
            repeat (done_dly - 1) tick();
            xdone = 1'b1;
            tick();
            xdone = 1'b0;
            chk("done_pulse", 64'(frame_done), 64'd1);
            chk("ready_after_done", 64'(ready), 64'd1);
            tick();
            chk("done_pulse_width", 64'(frame_done), 64'd0);
        end else begin
            n = 0;
            while (!ready) begin tick(); n++; if (n > 50) bound_fail("wait_timeout"); end
            chk("timeout_cycles", 64'(n), 64'(TO));
            chk("timeout_err", 64'(err), 64'd1);
            chk("timeout_no_done", 64'(frame_done), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        finish_run();
    end

    initial begin
        logic [3:0] lk;
        int         n;
        rst_n = 1'b0; en = 1'b1; key = 4'd0; msg = 8'd0; valid = 1'b0; xdone = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {58'd0, ready, data, load_key, load_msg, frame_done, err}, 64'd0);
        rst_n = 1'b1;
        chk("ready_before_edge", 64'(ready), 64'd0);
        tick();
        chk("ready_after_release", 64'(ready), 64'd1);

        run_frame(4'b1011, 8'b10001001, 0, 0, 3, 1'b1, 1'b1);
        run_frame(4'h5, 8'hA5, 2, 5, 2, 1'b0, 1'b0);
        chk("stall_key_high", 64'(last_kh), 64'd13);
        run_frame(4'h6, 8'h3C, 0, 0, 0, 1'b0, 1'b0);
        run_frame(4'hB, 8'h5A, 0, 0, 1, 1'b0, 1'b0);
        run_frame(4'hB, 8'hC3, 0, 0, 2, 1'b0, 1'b0);
        run_frame(4'h3, 8'h0F, 0, 0, 4, 1'b0, 1'b0);

        lk = 4'h3;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] rk;
            rk = ($urandom_range(0, 1) == 1) ? lk : 4'($urandom_range(0, 15));
            lk = rk;
            run_frame(rk, 8'($urandom_range(0, 255)),
                      int'($urandom_range(0, 6)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                      ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abort mid-MSG: strobes must drop asynchronously and the frame must vanish.
        n = 0;
        while (!ready) begin tick(); n++; if (n > 100) bound_fail("abort_ready"); end
        expq.push_back(mk(4'h9, 8'h66, 1'b0, 1'b0));
        key = 4'h9; msg = 8'h66; valid = 1'b1;
        tick();
        valid = 1'b0;
        n = 0;
        while (!load_msg) begin tick(); n++; if (n > 100) bound_fail("abort_msg"); end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_msg_drop", 64'(load_msg), 64'd0);
        chk("abort_key_low", 64'(load_key), 64'd0);
        void'(expq.pop_back());
        mc_vld = 1'b0;
        repeat (3) tick();
        chk("abort_no_done", 64'(frame_done), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_ready", 64'(ready), 64'd1);
        run_frame(4'h9, 8'h99, 1, 2, 3, 1'b0, 1'b0);

        repeat (3) tick();
        chk("queue_empty", 64'(expq.size()), 64'd0);
        chk("strobe_overlap", 64'(overlap), 64'd0);
        finish_run();
    end
endmodule
